// File: rtl/cplx_alu_seq.sv
// Multi-cycle complex ALU on packed {RE, IM} words with a start/busy/done handshake.
// A single signed WxW multiplier is shared across all product terms of ops 4..6.
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | one step per edge; k selects the product term
// DONE  | done pulse; a new start is accepted here as in IDLE
module cplx_alu_seq #(
  parameter int W    = 16,
  parameter int FRAC = 0
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [3:0]     opr,
  input  logic [2*W-1:0] inA,
  input  logic [2*W-1:0] inB,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] outAB,
  output logic           ovf,
  output logic           err
);
  localparam int PW = 2*W;
  localparam int AW = 2*W+2;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t               state;
  logic [3:0]           op_q;
  logic [2*W-1:0]       a_q, b_q;
  logic [1:0]           k;
  logic signed [AW-1:0] acc_re, acc_im;

  logic signed [W-1:0]  ar, ai, br, bi;
  logic signed [W-1:0]  mul_x, mul_y;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] term, acc_re_nxt, acc_im_nxt;
  logic signed [AW-1:0] res_re, res_im;
  logic                 to_re, neg, last_step, res_err, res_ovf;

  assign ar = a_q[2*W-1:W];
  assign ai = a_q[W-1:0];
  assign br = b_q[2*W-1:W];
  assign bi = b_q[W-1:0];

  // Product schedule: op4 k=0..3 -> ArBr, -AiBi, ArBi, AiBr; op5/op6 use k=0..1.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    to_re = 1'b1;
    neg   = 1'b0;
    case (op_q)
      4'd4: begin
        case (k)
          2'd0: begin mul_x = ar; mul_y = br; end
          2'd1: begin mul_x = ai; mul_y = bi; neg = 1'b1; end
          2'd2: begin mul_x = ar; mul_y = bi; to_re = 1'b0; end
          default: begin mul_x = ai; mul_y = br; to_re = 1'b0; end
        endcase
      end
      4'd5: begin
        if (k[0]) begin mul_x = ai; mul_y = bi; to_re = 1'b0; end
        else begin mul_x = ar; mul_y = br; end
      end
      4'd6: begin
        if (k[0]) begin mul_x = ai; mul_y = ai; end
        else begin mul_x = ar; mul_y = ar; end
      end
      default: ;
    endcase
    prod       = PW'(mul_x) * PW'(mul_y);
    term       = neg ? -AW'(prod) : AW'(prod);
    acc_re_nxt = to_re ? acc_re + term : acc_re;
    acc_im_nxt = to_re ? acc_im : acc_im + term;
  end

  always_comb begin
    case (op_q)
      4'd4:       last_step = (k == 2'd3);
      4'd5, 4'd6: last_step = (k == 2'd1);
      default:    last_step = 1'b1;
    endcase
  end

  always_comb begin
    res_re  = '0;
    res_im  = '0;
    res_err = 1'b0;
    case (op_q)
      4'd0: begin res_re = AW'(ar); res_im = AW'(ai); end
      4'd1: begin res_re = AW'(br); res_im = AW'(bi); end
      4'd2: begin res_re = AW'(ar) + AW'(br); res_im = AW'(ai) + AW'(bi); end
      4'd3: begin res_re = AW'(ar) - AW'(br); res_im = AW'(ai) - AW'(bi); end
      4'd4, 4'd5, 4'd6: begin
        res_re = acc_re_nxt >>> FRAC;
        res_im = acc_im_nxt >>> FRAC;
      end
      4'd7: res_im = (a_q == b_q) ? AW'(1) : '0;
      default: res_err = 1'b1;
    endcase
    // In range iff every bit from the W-bit sign position upward agrees.
    res_ovf = !((&res_re[AW-1:W-1]) || !(|res_re[AW-1:W-1])) ||
              !((&res_im[AW-1:W-1]) || !(|res_im[AW-1:W-1]));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      k      <= '0;
      acc_re <= '0;
      acc_im <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      outAB  <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        EXEC: begin
          if (last_step) begin
            outAB <= {res_re[W-1:0], res_im[W-1:0]};
            ovf   <= res_ovf;
            err   <= res_err;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            k      <= k + 2'd1;
            acc_re <= acc_re_nxt;
            acc_im <= acc_im_nxt;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            op_q   <= opr;
            a_q    <= inA;
            b_q    <= inB;
            k      <= '0;
            acc_re <= '0;
            acc_im <= '0;
            busy   <= 1'b1;
            state  <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_alu_seq.sv
// Scoreboard bench for cplx_alu_seq: integer (FRAC=0) and Q8.8 (FRAC=8) instances run in lockstep.
module tb_cplx_alu_seq;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  opr;
  logic [31:0] inA, inB;
  logic        busy0, done0, ovf0, err0;
  logic [31:0] out0;
  logic        busy8, done8, ovf8, err8;
  logic [31:0] out8;

  cplx_alu_seq #(.W(16), .FRAC(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .opr(opr), .inA(inA), .inB(inB),
    .busy(busy0), .done(done0), .outAB(out0), .ovf(ovf0), .err(err0));

  cplx_alu_seq #(.W(16), .FRAC(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start), .opr(opr), .inA(inA), .inB(inB),
    .busy(busy8), .done(done8), .outAB(out8), .ovf(ovf8), .err(err8));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed { logic [31:0] out; logic ovf; logic err; } res_t;
  typedef struct { int acc; int steps; res_t r0; res_t r8; } item_t;

  item_t sb[$];
  res_t  last0, last8;
  int    vectors = 0;
  int    miscompares = 0;
  int    free_cyc = 0;

  function automatic logic [31:0] pk(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic int steps_of(input logic [3:0] op);
    case (op)
      4'd4:       return 4;
      4'd5, 4'd6: return 2;
      default:    return 1;
    endcase
  endfunction

  // Reference: plain integer complex arithmetic, then shift, range check and 16-bit wrap.
  function automatic res_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int frac);
    res_t   r;
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(a[31:16]));
    ai = longint'($signed(a[15:0]));
    br = longint'($signed(b[31:16]));
    bi = longint'($signed(b[15:0]));
    re = 0;
    im = 0;
    r.err = 1'b0;
    case (op)
      4'd0: begin re = ar; im = ai; end
      4'd1: begin re = br; im = bi; end
      4'd2: begin re = ar + br; im = ai + bi; end
      4'd3: begin re = ar - br; im = ai - bi; end
      4'd4: begin re = (ar*br - ai*bi) >>> frac; im = (ar*bi + ai*br) >>> frac; end
      4'd5: begin re = (ar*br) >>> frac; im = (ai*bi) >>> frac; end
      4'd6: begin re = (ar*ar + ai*ai) >>> frac; im = 0; end
      4'd7: im = (a == b) ? 1 : 0;
      default: r.err = 1'b1;
    endcase
    r.ovf = (re > 32767) || (re < -32768) || (im > 32767) || (im < -32768);
    r.out = {re[15:0], im[15:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle, compare handshake and held outputs against the scoreboard.
  initial begin : monitor
    int d;
    bit eb, ed;
    last0 = '0;
    last8 = '0;
    @(negedge reset_n);
    forever begin
      @(negedge clock);
      eb = 1'b0;
      ed = 1'b0;
      if (sb.size() > 0) begin
        d  = cyc - sb[0].acc;
        eb = (d >= 0) && (d < sb[0].steps);
        ed = (d == sb[0].steps);
        if (ed) begin
          last0 = sb[0].r0;
          last8 = sb[0].r8;
          void'(sb.pop_front());
        end
      end
      check("busy",   32'(busy0), 32'(eb));
      check("done",   32'(done0), 32'(ed));
      check("outAB",  out0,       last0.out);
      check("ovf",    32'(ovf0),  32'(last0.ovf));
      check("err",    32'(err0),  32'(last0.err));
      check("busy8",  32'(busy8), 32'(eb));
      check("done8",  32'(done8), 32'(ed));
      check("outAB8", out8,       last8.out);
      check("ovf8",   32'(ovf8),  32'(last8.ovf));
      check("err8",   32'(err8),  32'(last8.err));
    end
  end

  // Called at a negedge; while the model says busy, drives ignored junk commands.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    item_t it;
    while (cyc < free_cyc) begin
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      opr   = 4'($urandom);
      inA   = $urandom;
      inB   = $urandom;
      @(negedge clock);
    end
    start    = 1'b1;
    opr      = op;
    inA      = a;
    inB      = b;
    it.acc   = cyc + 1;
    it.steps = steps_of(op);
    it.r0    = model(op, a, b, 0);
    it.r8    = model(op, a, b, 8);
    sb.push_back(it);
    free_cyc = it.acc + it.steps;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [31:0] rand_word();
    if ($urandom_range(0, 2) == 0) return $urandom;
    return pk(int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 400)) - 200);
  endfunction

  initial begin : driver
    logic [3:0]  op;
    logic [31:0] a, b;
    reset_n = 1'b1;
    start   = 1'b0;
    opr     = '0;
    inA     = '0;
    inB     = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    issue(4'd2, pk(100, -5), pk(-30, 7), 1'b0);
    issue(4'd2, pk(32767, 0), pk(1, 0), 1'b0);
    issue(4'd4, pk(3, 4), pk(5, -2), 1'b1);
    issue(4'd5, 32'h0180_0200, 32'h0200_FF00, 1'b1);
    issue(4'd7, pk(9, 9), pk(9, 9), 1'b0);
    issue(4'd7, pk(9, 9), pk(9, 8), 1'b0);
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    issue(4'd0, pk(-7, 11), pk(1, 2), 1'b0);
    issue(4'd6, pk(-32768, -32768), 32'h0, 1'b1);
    issue(4'd4, pk(-32768, -32768), pk(-32768, -32768), 1'b0);
    issue(4'd3, pk(-32768, 5), pk(1, 2), 1'b0);
    issue(4'd1, pk(-1, 32767), pk(-300, 44), 1'b0);
    idle(3);

    // Abort a complex multiply after two of its four steps.
    issue(4'd3, pk(-32768, 5), pk(1, 2), 1'b0);
    issue(4'd4, pk(7, -3), pk(2, 9), 1'b0);
    start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    sb.delete();
    last0    = '0;
    last8    = '0;
    free_cyc = 0;
    #1;
    check("rst_busy",  32'(busy0), 32'd0);
    check("rst_done",  32'(done0), 32'd0);
    check("rst_outAB", out0,       32'd0);
    check("rst_ovf",   32'(ovf0),  32'd0);
    check("rst_err",   32'(err0),  32'd0);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_outAB8", out8,      32'd0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    idle(8);

    repeat (300) begin
      op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      a  = rand_word();
      b  = (op == 4'd7 && $urandom_range(0, 1) == 1) ? a : rand_word();
      issue(op, a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    start = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    vectors++;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d results still pending, expected 0", sb.size());
    end
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not complete, expected completion by 500000");
    $fatal(1, "timeout");
  end

endmodule
